// File: rtl/keypad_pkg.sv
// Shared geometry constants, FSM state types and key-map helpers for the keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned KEY_W    = 4;
  localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int unsigned CNT_W    = KEY_W + 1;

  typedef enum logic {
    SCAN_PARK,
    SCAN_DRIVE
  } scan_state_e;

  typedef enum logic [1:0] {
    PRESS_RELEASED,
    PRESS_PRESSED,
    PRESS_MULTI
  } press_state_e;

  function automatic logic [CNT_W-1:0] count_keys(input logic [NUM_KEYS-1:0] map);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      n = n + CNT_W'(map[i]);
    end
    return n;
  endfunction

  // Only meaningful when exactly one bit of the map is set.
  function automatic logic [KEY_W-1:0] key_index(input logic [NUM_KEYS-1:0] map);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (map[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, synchronous active-high reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset_in) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row-at-a-time drive, whole-frame debounce and
// classification of the accepted map into single-press / multi-key states.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 12000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                reset_in,
  input  logic                scan_en,
  output logic [NUM_ROWS-1:0] row_out,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_KEYS-1:0] key_map,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                multi_key
);

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
  localparam int unsigned ROW_W  = $clog2(NUM_ROWS);
  localparam int unsigned STAB_W = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_ROWS - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE_FRAMES);

  scan_state_e         scan_q, scan_d;
  press_state_e        press_q, press_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [NUM_KEYS-1:0] frame_q, frame_d;
  logic [NUM_KEYS-1:0] prev_q, prev_d;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic [NUM_KEYS-1:0] key_map_q, key_map_d;
  logic [KEY_W-1:0]    key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;

  logic [NUM_COLS-1:0] col_sync;
  logic [NUM_KEYS-1:0] snapshot;
  logic [CNT_W-1:0]    n_keys;
  logic                frame_end;
  logic                map_update;

  sync_2ff #(
    .WIDTH(NUM_COLS)
  ) u_col_sync (
    .clk     (clk),
    .reset_in(reset_in),
    .d_in    (col_in),
    .q_out   (col_sync)
  );

  always_comb begin
    scan_d      = scan_q;
    slot_d      = slot_q;
    row_d       = row_q;
    frame_d     = frame_q;
    prev_d      = prev_q;
    stab_d      = stab_q;
    key_map_d   = key_map_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    press_d     = press_q;
    frame_end   = 1'b0;
    map_update  = 1'b0;
    n_keys      = '0;

    // Current row's inverted columns merged over the rows already captured this frame.
    snapshot = frame_q;
    snapshot[row_q * NUM_COLS +: NUM_COLS] = ~col_sync;

    case (scan_q)
      SCAN_PARK: begin
        slot_d = '0;
        row_d  = '0;
        if (scan_en) scan_d = SCAN_DRIVE;
      end
      SCAN_DRIVE: begin
        if (slot_q == SLOT_LAST) begin
          slot_d  = '0;
          frame_d = snapshot;
          if (row_q == ROW_LAST) begin
            frame_end = 1'b1;
            row_d     = '0;
            if (!scan_en) scan_d = SCAN_PARK;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: scan_d = SCAN_PARK;
    endcase

    if (frame_end) begin
      prev_d = snapshot;
      if (snapshot == prev_q) begin
        stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
      end else begin
        stab_d = STAB_W'(1);
      end
      map_update = (stab_d == STAB_MAX) && (snapshot != key_map_q);
    end

    if (map_update) begin
      key_map_d = snapshot;
      n_keys    = count_keys(snapshot);
      if (n_keys == '0) begin
        press_d = PRESS_RELEASED;
      end else if (n_keys == CNT_W'(1)) begin
        // A single key only counts as a press when coming from an all-released map.
        if (press_q == PRESS_RELEASED) begin
          press_d     = PRESS_PRESSED;
          key_code_d  = key_index(snapshot);
          key_valid_d = 1'b1;
        end else begin
          press_d = PRESS_MULTI;
        end
      end else begin
        press_d = PRESS_MULTI;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      scan_q      <= SCAN_PARK;
      press_q     <= PRESS_RELEASED;
      slot_q      <= '0;
      row_q       <= '0;
      frame_q     <= '0;
      prev_q      <= '0;
      stab_q      <= '0;
      key_map_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      scan_q      <= scan_d;
      press_q     <= press_d;
      slot_q      <= slot_d;
      row_q       <= row_d;
      frame_q     <= frame_d;
      prev_q      <= prev_d;
      stab_q      <= stab_d;
      key_map_q   <= key_map_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign row_out   = (scan_q == SCAN_DRIVE) ? ~(NUM_ROWS'(1) << row_q) : '1;
  assign key_map   = key_map_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (press_q == PRESS_PRESSED);
  assign multi_key = (press_q == PRESS_MULTI);

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized self-checking bench for keypad_scanner against a frame-level behavioural model.
module tb_keypad_scanner;

  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        scan_en;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic [15:0] key_map;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;
  logic [15:0] keys;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;

  // Behavioural model state; m_press: 0 released, 1 pressed, 2 multi.
  bit          m_on;
  int          m_pos;
  logic [15:0] m_frame;
  logic [15:0] m_map;
  logic [3:0]  m_code;
  bit          m_valid;
  int          m_press;
  logic [3:0]  m_c1;
  logic [3:0]  m_c2;
  logic [15:0] m_hist[$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_FRAMES(DB)
  ) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .scan_en  (scan_en),
    .row_out  (row_out),
    .col_in   (col_in),
    .key_map  (key_map),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .multi_key(multi_key)
  );

  // A pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_out[r]) col_in = col_in & ~keys[4*r +: 4];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int popcount(input logic [15:0] m);
    int n = 0;
    for (int i = 0; i < 16; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic logic [3:0] first_key(input logic [15:0] m);
    logic [3:0] k = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) k = 4'(i);
    return k;
  endfunction

  task automatic accept_map(input logic [15:0] m);
    int n;
    n     = popcount(m);
    m_map = m;
    if (n == 0) m_press = 0;
    else if (n >= 2) m_press = 2;
    else if (m_press == 0) begin
      m_press = 1;
      m_code  = first_key(m);
      m_valid = 1'b1;
    end else m_press = 2;
  endtask

  // Advances the model across one rising edge using the inputs present before it.
  task automatic model_edge();
    logic [3:0] col_pre;
    logic [3:0] samp;
    int run;
    bit same;
    if (reset_in) begin
      m_on = 0; m_pos = 0; m_frame = '0; m_map = '0; m_code = '0;
      m_valid = 0; m_press = 0; m_c1 = '0; m_c2 = '0;
      m_hist.delete();
      return;
    end
    col_pre = m_on ? ~keys[4*(m_pos/SD) +: 4] : 4'hF;
    samp    = ~m_c2;
    m_c2    = m_c1;
    m_c1    = col_pre;
    m_valid = 0;
    if (m_on) begin
      if (m_pos % SD == SD - 1) m_frame[4*(m_pos/SD) +: 4] = samp;
      if (m_pos == FRAME - 1) begin
        m_hist.push_back(m_frame);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        run = 0; same = 1;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
          if (same && m_hist[i] == m_frame) run++;
          else same = 0;
        end
        if (run >= DB && m_frame != m_map) accept_map(m_frame);
        m_pos = 0;
        if (!scan_en) m_on = 0;
      end else m_pos++;
    end else if (scan_en) begin
      m_on  = 1;
      m_pos = 0;
    end
  endtask

  task automatic step();
    logic [3:0] exp_row;
    @(posedge clk);
    model_edge();
    #1;
    exp_row = 4'hF;
    if (m_on) exp_row[m_pos/SD] = 1'b0;
    check_eq("row_out",   32'(row_out),   32'(exp_row));
    check_eq("key_map",   32'(key_map),   32'(m_map));
    check_eq("key_code",  32'(key_code),  32'(m_code));
    check_eq("key_valid", 32'(key_valid), 32'(m_valid));
    check_eq("key_held",  32'(key_held),  32'(m_press == 1));
    check_eq("multi_key", 32'(multi_key), 32'(m_press == 2));
    if (key_valid) vcount++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_in = 1'b1;
    scan_en  = 1'b0;
    keys     = '0;
    run(3);
    check_eq("reset_row", 32'(row_out), 32'hF);
    check_eq("reset_map", 32'(key_map), 32'h0);

    // Idle scanning: row sequence and no presses
    reset_in = 1'b0;
    scan_en  = 1'b1;
    vcount   = 0;
    run(4 * FRAME);
    check_eq("idle_valid_cnt", 32'(vcount), 32'd0);

    // Single key row 2 / col 1
    keys = 16'h0200;
    run(4 * FRAME);
    check_eq("k9_map",  32'(key_map),  32'h0200);
    check_eq("k9_code", 32'(key_code), 32'd9);
    check_eq("k9_held", 32'(key_held), 32'd1);
    check_eq("k9_valid_cnt", 32'(vcount), 32'd1);
    keys = '0;
    run(4 * FRAME);
    check_eq("k9_rel_held", 32'(key_held), 32'd0);

    // Half-frame bounce then steady hold: exactly one press overall
    vcount = 0;
    for (int t = 0; t < 12; t++) begin
      keys = (t % 2 == 0) ? 16'h0200 : 16'h0000;
      run(8);
    end
    keys = 16'h0200;
    run(4 * FRAME);
    check_eq("bounce8_valid_cnt", 32'(vcount), 32'd1);
    keys = '0;
    run(4 * FRAME);

    // Frame-rate bounce never stabilises
    vcount = 0;
    for (int t = 0; t < 6; t++) begin
      keys = (t % 2 == 0) ? 16'h0200 : 16'h0000;
      run(FRAME);
    end
    check_eq("bounce16_map", 32'(key_map), 32'h0);
    check_eq("bounce16_valid_cnt", 32'(vcount), 32'd0);
    keys = 16'h0200;
    run(4 * FRAME);
    check_eq("bounce16_hold_cnt", 32'(vcount), 32'd1);
    keys = '0;
    run(4 * FRAME);

    // Two keys together, partial release, full release
    vcount = 0;
    keys = 16'h0021;
    run(4 * FRAME);
    check_eq("mk_map",   32'(key_map),   32'h0021);
    check_eq("mk_multi", 32'(multi_key), 32'd1);
    keys = 16'h0001;
    run(4 * FRAME);
    check_eq("mk_part_map",   32'(key_map),   32'h0001);
    check_eq("mk_part_multi", 32'(multi_key), 32'd1);
    keys = '0;
    run(4 * FRAME);
    check_eq("mk_rel_multi", 32'(multi_key), 32'd0);
    check_eq("mk_rel_held",  32'(key_held),  32'd0);
    check_eq("mk_valid_cnt", 32'(vcount), 32'd0);

    // scan_en dropped during row 1 with a key accepted
    keys = 16'h0008;
    run(4 * FRAME);
    for (int i = 0; i < FRAME && (m_pos / SD) != 1; i++) step();
    scan_en = 1'b0;
    run(FRAME + 2);
    check_eq("park_row", 32'(row_out), 32'hF);
    check_eq("park_map", 32'(key_map), 32'h0008);
    scan_en = 1'b1;
    keys = '0;
    run(4 * FRAME);

    // Reset in the middle of a press
    keys = 16'h0200;
    run(3 * FRAME + int'($urandom_range(0, FRAME - 1)));
    reset_in = 1'b1;
    step();
    check_eq("rst_row",   32'(row_out),   32'hF);
    check_eq("rst_map",   32'(key_map),   32'h0);
    check_eq("rst_code",  32'(key_code),  32'h0);
    check_eq("rst_valid", 32'(key_valid), 32'h0);
    check_eq("rst_held",  32'(key_held),  32'h0);
    check_eq("rst_multi", 32'(multi_key), 32'h0);
    reset_in = 1'b0;
    keys = '0;
    run(3 * FRAME);

    // Randomized key patterns, enable toggles and occasional resets
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: keys = '0;
        3, 4, 5, 9: keys = 16'(1) << $urandom_range(0, 15);
        6, 7: keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: keys = 16'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) scan_en = ~scan_en;
      if ($urandom_range(0, 29) == 0) begin
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
      end
      run(int'($urandom_range(1, 48)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
